// File: rtl/sequence_detector.sv
//-----------------------------------------------------------------------------
// Module      : sequence_detector
// Description : Serial pattern detector. Shifts in one bit per qualified clock,
//               pulses match for one cycle whenever the last PAT_LEN sampled
//               bits equal PATTERN, and keeps a saturating match count.
//               Build option: define SEQ_DET_OVERLAP_EN for overlapping
//               detection; leave it undefined for non-overlapping detection.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module sequence_detector #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic             din,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);

   // fill counts 0..PAT_LEN inclusive
   localparam int FILL_W = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HUNT = 1'b1
   } state_t;

   state_t             state, state_d;
   logic [PAT_LEN-1:0] hist, hist_d, next_hist;
   logic [FILL_W-1:0]  fill, fill_d, fill_inc;
   logic [CNT_W-1:0]   cnt_d;
   logic               match_d;
   logic               hit;

   // State register; reset and clr both return the detector to FILL
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_FILL;
      end else begin
         state <= state_d;
      end
   end

   // Datapath registers: history, fill level, match pulse and counter
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hist      <= '0;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
      end else begin
         hist      <= hist_d;
         fill      <= fill_d;
         match     <= match_d;
         match_cnt <= cnt_d;
      end
   end

   // Next-state, shift, compare and count logic (defaults hold everything)
   always_comb begin
      next_hist = {hist[PAT_LEN-2:0], din};
      fill_inc  = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      // fill must reach PAT_LEN so reset zeros never count as real samples
      hit       = in_valid && (next_hist == PATTERN) && (fill_inc == FILL_FULL);

      state_d = state;
      hist_d  = hist;
      fill_d  = fill;
      cnt_d   = match_cnt;
      match_d = 1'b0;

      if (clr) begin
         // clr wins over a coincident sample, which is dropped uncounted
         state_d = ST_FILL;
         hist_d  = '0;
         fill_d  = '0;
         cnt_d   = '0;
      end else if (in_valid) begin
         hist_d  = next_hist;
         fill_d  = fill_inc;
         match_d = hit;
         if (hit && (match_cnt != CNT_MAX)) begin
            cnt_d = match_cnt + CNT_W'(1);
         end

         case (state)
            ST_FILL: begin
               if (fill_inc == FILL_FULL) begin
                  state_d = ST_HUNT;
               end
            end
            ST_HUNT: begin
               state_d = ST_HUNT;
            end
            default: begin
               state_d = ST_FILL;
            end
         endcase

`ifdef SEQ_DET_OVERLAP_EN
         // history is kept so the tail of one match can start the next
`else
         // the next match must be built from PAT_LEN fresh bits
         if (hit) begin
            fill_d  = '0;
            state_d = ST_FILL;
         end
`endif
      end
   end

   assign armed = (state == ST_HUNT);

endmodule

`default_nettype wire

// File: tb/tb_sequence_detector.sv
`default_nettype none

module tb_sequence_detector;

   localparam int         PAT_LEN = 4;
   localparam logic [3:0] PAT     = 4'b1011;
`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif
   // armed level right after a match completes
   localparam logic ARM = OVL;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       din = 1'b0;
   logic       match8, armed8, match2, armed2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut8 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .din(din), .clr(clr),
      .match(match8), .match_cnt(cnt8), .armed(armed8)
   );

   sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .din(din), .clr(clr),
      .match(match2), .match_cnt(cnt2), .armed(armed2)
   );

   // Reference model: the list of real bits collected since the last
   // reset / clr / (non-overlap) match; a match is "at least PAT_LEN real
   // bits and the newest PAT_LEN of them spell PAT".
   bit q[$];
   bit m_match = 1'b0;
   int m_cnt8 = 0;
   int m_cnt2 = 0;

   task automatic model_step(input logic r, input logic c, input logic v, input logic d);
      logic [3:0] w;
      if (!r || c) begin
         q.delete();
         m_match = 1'b0;
         m_cnt8  = 0;
         m_cnt2  = 0;
      end else if (v) begin
         q.push_back(d);
         if (q.size() > PAT_LEN) void'(q.pop_front());
         w = '0;
         foreach (q[i]) w = {w[2:0], q[i]};
         m_match = (q.size() == PAT_LEN) && (w == PAT);
         if (m_match) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
            if (!OVL) q.delete();
         end
      end else begin
         m_match = 1'b0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("match8", int'(match8), int'(m_match));
      chk("cnt8",   int'(cnt8),   m_cnt8);
      chk("armed8", int'(armed8), int'(q.size() == PAT_LEN));
      chk("match2", int'(match2), int'(m_match));
      chk("cnt2",   int'(cnt2),   m_cnt2);
      chk("armed2", int'(armed2), int'(q.size() == PAT_LEN));
   endtask

   // Apply one cycle of inputs at negedge, sample just after the posedge
   task automatic drive(input logic r, input logic c, input logic v, input logic d);
      @(negedge clk);
      rstn = r; clr = c; in_valid = v; din = d;
      @(posedge clk);
      #1;
      model_step(r, c, v, d);
   endtask

   typedef struct {
      logic r, c, v, d;
      logic m;
      int   cnt;
      logic a;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, c, v, d, m, input int cnt, input logic a);
      vec_t e;
      e.r = r; e.c = c; e.v = v; e.d = d; e.m = m; e.cnt = cnt; e.a = a;
      tbl.push_back(e);
   endfunction

   initial begin
      int pulses;
      int exp5[5];
      exp5 = '{1, 2, 3, 3, 3};

      // reset held 3 clocks, then release with no samples
      add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
      add(1,0,0,0, 0,0,0);
      // 1011 -> pulse the cycle after the 4th bit, then drops
      add(1,0,1,1, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,1,1, 0,0,0);
      add(1,0,1,1, 1,1,ARM);
      add(1,0,0,0, 0,1,ARM);
      // 1011 with two idle cycles between bits
      add(1,1,0,0, 0,0,0);
      add(1,0,1,1, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0);
      add(1,0,1,0, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0);
      add(1,0,1,1, 0,0,0); add(1,0,0,0, 0,0,0); add(1,0,0,0, 0,0,0);
      add(1,0,1,1, 1,1,ARM);
      add(1,0,0,0, 0,1,ARM); add(1,0,0,0, 0,1,ARM);
      // clr coincident with the completing bit
      add(1,1,0,0, 0,0,0);
      add(1,0,1,1, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,1,1, 0,0,0);
      add(1,1,1,1, 0,0,0);
      // reset mid-stream after 1,0,1, then a single 1
      add(1,0,1,1, 0,0,0); add(1,0,1,0, 0,0,0); add(1,0,1,1, 0,0,0);
      add(0,0,0,0, 0,0,0);
      add(1,0,1,1, 0,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d.match", i), int'(match8), int'(tbl[i].m));
         chk($sformatf("tbl%0d.cnt",   i), int'(cnt8),   tbl[i].cnt);
         chk($sformatf("tbl%0d.armed", i), int'(armed8), int'(tbl[i].a));
      end

      // 1011011: overlap gives two pulses, non-overlap one
      drive(1, 1, 0, 0);
      pulses = 0;
      for (int i = 6; i >= 0; i--) begin
         logic [6:0] s;
         s = 7'b1011011;
         drive(1, 0, 1, s[i]);
         check_model();
         if (match8) pulses++;
      end
      chk("ovl.pulses", pulses, OVL ? 2 : 1);
      chk("ovl.cnt8", int'(cnt8), OVL ? 2 : 1);

      // 2-bit counter saturates at 3 while match keeps pulsing
      drive(1, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 1, 1'b1); drive(1, 0, 1, 1'b0); drive(1, 0, 1, 1'b1);
         drive(1, 0, 1, 1'b1);
         chk($sformatf("sat%0d.match2", k), int'(match2), 1);
         chk($sformatf("sat%0d.cnt2", k), int'(cnt2), exp5[k]);
      end
      drive(1, 0, 0, 0);
      chk("sat.gap.match2", int'(match2), 0);
      chk("sat.gap.cnt2", int'(cnt2), 3);

      // randomized stream against the reference model
      for (int n = 0; n < 3000; n++) begin
         logic r, c, v, d;
         r = ($urandom_range(0, 149) != 0);
         c = ($urandom_range(0, 79) == 0);
         v = ($urandom_range(0, 3) != 0);
         d = $urandom_range(0, 1);
         drive(r, c, v, d);
         check_model();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
